// File: rtl/dl_shift_pkg.sv
// Shared definitions for the pipelined barrel shifter: op encodings, bit reversal
// for SLL, and the level-to-stage mapping.
package dl_shift_pkg;

    typedef enum logic [1:0] {
        SHIFT_SLL = 2'b00,
        SHIFT_SRL = 2'b01,
        SHIFT_SRA = 2'b10,
        SHIFT_ROR = 2'b11
    } shift_op_t;

    // Fixed reversal width; callers zero-extend into it and realign, so NUM_BITS <= 64.
    localparam int REV_BITS = 64;

    function automatic logic [REV_BITS-1:0] bit_reverse(input logic [REV_BITS-1:0] v);
        logic [REV_BITS-1:0] r;
        for (int i = 0; i < REV_BITS; i++) begin
            r[i] = v[REV_BITS-1-i];
        end
        return r;
    endfunction

    // First mux level owned by a stage: smallest i with floor(i*stages/levels) == stage.
    function automatic int first_level(input int stage, input int num_levels, input int num_stages);
        return (stage * num_levels + num_stages - 1) / num_stages;
    endfunction

endpackage

// File: rtl/dl_shift_stage.sv
// One pipeline stage: a run of right-shift mux levels followed by its register slice.
// DL_SHIFT_PIPE_ROT_EN adds the rotate wrap path; otherwise ROR behaves as SRL.
module dl_shift_stage
    import dl_shift_pkg::*;
#(
    parameter int NUM_BITS       = 32,
    parameter int NUM_SHIFT_BITS = 5,
    parameter int TAG_BITS       = 5,
    parameter int FIRST_LEVEL    = 0,
    parameter int NUM_LEVELS     = 1,
    parameter bit LAST           = 1'b0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [NUM_BITS-1:0]       in_data,
    input  logic [NUM_SHIFT_BITS-1:0] in_shift,
    input  shift_op_t                 in_op,
    input  logic [TAG_BITS-1:0]       in_tag,
    input  logic                      in_fill,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [NUM_BITS-1:0]       out_data,
    output logic [NUM_SHIFT_BITS-1:0] out_shift,
    output shift_op_t                 out_op,
    output logic [TAG_BITS-1:0]       out_tag,
    output logic                      out_fill
);

    logic [NUM_BITS-1:0] lvl [0:NUM_LEVELS];
    logic [NUM_BITS-1:0] result;

    assign lvl[0] = in_data;

    for (genvar j = 0; j < NUM_LEVELS; j++) begin : g_level
        localparam int AMT = 1 << (FIRST_LEVEL + j);
        logic [NUM_BITS-1:0] wrap;
`ifdef DL_SHIFT_PIPE_ROT_EN
        assign wrap = (in_op == SHIFT_ROR) ? (lvl[j] << (NUM_BITS - AMT))
                                           : (in_fill ? ~({NUM_BITS{1'b1}} >> AMT) : '0);
`else
        assign wrap = in_fill ? ~({NUM_BITS{1'b1}} >> AMT) : '0;
`endif
        assign lvl[j+1] = in_shift[FIRST_LEVEL+j] ? ((lvl[j] >> AMT) | wrap) : lvl[j];
    end

    // SLL entered the pipe bit-reversed; the last stage turns it back around.
    if (LAST) begin : g_unrev
        assign result = (in_op == SHIFT_SLL)
                      ? NUM_BITS'(bit_reverse(REV_BITS'(lvl[NUM_LEVELS])) >> (REV_BITS - NUM_BITS))
                      : lvl[NUM_LEVELS];
    end else begin : g_pass
        assign result = lvl[NUM_LEVELS];
    end

    assign in_ready = !out_valid || out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_shift <= '0;
            out_op    <= SHIFT_SLL;
            out_tag   <= '0;
            out_fill  <= 1'b0;
        end else if (in_ready) begin
            out_valid <= in_valid;
            if (in_valid) begin
                out_data  <= result;
                out_shift <= in_shift;
                out_op    <= in_op;
                out_tag   <= in_tag;
                out_fill  <= in_fill;
            end
        end
    end

endmodule

// File: rtl/dl_shift_pipe.sv
// Pipelined barrel shifter (SLL/SRL/SRA/ROR) with per-stage valid/ready.
// DL_SHIFT_PIPE_ROT_EN enables rotate-right for op 11; without it op 11 is SRL.
module dl_shift_pipe
    import dl_shift_pkg::*;
#(
    parameter int  NUM_BITS       = 32,
    parameter int  NUM_STAGES     = 2,
    parameter int  TAG_BITS       = 5,
    localparam int NUM_SHIFT_BITS = $clog2(NUM_BITS)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [NUM_BITS-1:0]       in_a,
    input  logic [NUM_SHIFT_BITS-1:0] in_shift,
    input  logic [1:0]                in_op,
    input  logic [TAG_BITS-1:0]       in_tag,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [NUM_BITS-1:0]       out_data,
    output logic [TAG_BITS-1:0]       out_tag
);

    logic [NUM_STAGES:0]       v;
    logic [NUM_STAGES:0]       rdy;
    logic [NUM_BITS-1:0]       data  [0:NUM_STAGES];
    logic [NUM_SHIFT_BITS-1:0] shift [0:NUM_STAGES];
    shift_op_t                 op    [0:NUM_STAGES];
    logic [TAG_BITS-1:0]       tag   [0:NUM_STAGES];
    logic                      fill  [0:NUM_STAGES];

    // Every op is done as a right shift; SLL is pre-reversed here and undone in the last stage.
    assign v[0]     = in_valid;
    assign data[0]  = (in_op == SHIFT_SLL)
                    ? NUM_BITS'(bit_reverse(REV_BITS'(in_a)) >> (REV_BITS - NUM_BITS))
                    : in_a;
    assign shift[0] = in_shift;
    assign op[0]    = shift_op_t'(in_op);
    assign tag[0]   = in_tag;
    assign fill[0]  = (in_op == SHIFT_SRA) && in_a[NUM_BITS-1];

    assign rdy[NUM_STAGES] = out_ready;
    assign in_ready        = rdy[0];
    assign out_valid       = v[NUM_STAGES];
    assign out_data        = data[NUM_STAGES];
    assign out_tag         = tag[NUM_STAGES];

    for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
        localparam int FIRST = first_level(k, NUM_SHIFT_BITS, NUM_STAGES);
        localparam int NEXT  = first_level(k + 1, NUM_SHIFT_BITS, NUM_STAGES);

        dl_shift_stage #(
            .NUM_BITS       (NUM_BITS),
            .NUM_SHIFT_BITS (NUM_SHIFT_BITS),
            .TAG_BITS       (TAG_BITS),
            .FIRST_LEVEL    (FIRST),
            .NUM_LEVELS     (NEXT - FIRST),
            .LAST           (k == NUM_STAGES - 1)
        ) u_stage (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (v[k]),
            .in_ready  (rdy[k]),
            .in_data   (data[k]),
            .in_shift  (shift[k]),
            .in_op     (op[k]),
            .in_tag    (tag[k]),
            .in_fill   (fill[k]),
            .out_valid (v[k+1]),
            .out_ready (rdy[k+1]),
            .out_data  (data[k+1]),
            .out_shift (shift[k+1]),
            .out_op    (op[k+1]),
            .out_tag   (tag[k+1]),
            .out_fill  (fill[k+1])
        );
    end

endmodule

// File: tb/tb_dl_shift_pipe.sv
// Scoreboard bench for dl_shift_pipe: directed vectors on a 2-stage instance, plus
// random traffic on 1/3/5-stage instances checked against a reference model.
module tb_dl_shift_pipe;

    typedef struct {
        logic [31:0] data;
        logic [4:0]  tag;
        int          cyc;
        bit          chk_lat;
        bit          b2b;
    } exp_t;

`ifdef DL_SHIFT_PIPE_ROT_EN
    localparam logic [31:0] ROR_1_BY_1 = 32'h8000_0000;
`else
    localparam logic [31:0] ROR_1_BY_1 = 32'h0000_0000;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int          cyc = 0;
    int          checks = 0;
    int          passes = 0;

    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_a = '0;
    logic [4:0]  in_shift = '0;
    logic [1:0]  in_op = '0;
    logic [4:0]  in_tag = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_data;
    logic [4:0]  out_tag;

    exp_t        q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dl_shift_pipe #(.NUM_BITS(32), .NUM_STAGES(2), .TAG_BITS(5)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_shift  (in_shift),
        .in_op     (in_op),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_tag   (out_tag)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act === req) passes++;
        else $display("FAIL %s: got %0h required %0h", name, act, req);
    endtask

    function automatic logic [31:0] model(input logic [31:0] a, input logic [4:0] sh, input logic [1:0] op);
        case (op)
            2'b00:   return a << sh;
            2'b01:   return a >> sh;
            2'b10:   return $signed(a) >>> sh;
`ifdef DL_SHIFT_PIPE_ROT_EN
            default: return (a >> sh) | (a << (6'd32 - {1'b0, sh}));
`else
            default: return a >> sh;
`endif
        endcase
    endfunction

    task automatic send(input logic [31:0] a, input logic [4:0] sh, input logic [1:0] op,
                        input logic [4:0] tag, input logic [31:0] req, input bit push,
                        input bit lat, input bit b2b);
        bit   ok = 0;
        exp_t e;
        in_valid = 1'b1; in_a = a; in_shift = sh; in_op = op; in_tag = tag;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (in_ready) begin ok = 1; break; end
        end
        if (!ok) begin
            checks++;
            $display("FAIL send_timeout tag %0d: in_ready stayed 0, required 1", tag);
        end else if (push) begin
            e.data = req; e.tag = tag; e.cyc = cyc; e.chk_lat = lat; e.b2b = b2b;
            q.push_back(e);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Output monitor for the 2-stage instance.
    int          last_out_cyc = -10;
    bit          prev_stall = 0;
    logic [31:0] prev_data;
    logic [4:0]  prev_tag;

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            prev_stall = 0;
        end else begin
            if (prev_stall) begin
                check("stall_valid", 64'(out_valid), 64'(1));
                check("stall_data", 64'(out_data), 64'(prev_data));
                check("stall_tag", 64'(out_tag), 64'(prev_tag));
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    checks++;
                    $display("FAIL unexpected_output: got data %h tag %0d, required no output", out_data, out_tag);
                end else begin
                    e = q.pop_front();
                    check("data", 64'(out_data), 64'(e.data));
                    check("tag", 64'(out_tag), 64'(e.tag));
                    if (e.chk_lat) check("latency", 64'(cyc - e.cyc), 64'(2));
                    if (e.b2b) check("b2b_gap", 64'(cyc - last_out_cyc), 64'(1));
                end
                last_out_cyc = cyc;
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            prev_tag   = out_tag;
        end
    end

    // Random-traffic instances with 1, 3 and 5 stages share one stimulus bus.
    logic        sw_valid = 1'b0;
    logic        sw_ready = 1'b1;
    logic [31:0] sw_a = '0;
    logic [4:0]  sw_shift = '0;
    logic [1:0]  sw_op = '0;
    logic [4:0]  sw_tag = '0;
    bit          sw_lat = 0;
    logic        sw_done = 1'b0;

    for (genvar g = 0; g < 3; g++) begin : g_sw
        localparam int S = (g == 0) ? 1 : (g == 1) ? 3 : 5;
        logic        rdy;
        logic        ov;
        logic [31:0] od;
        logic [4:0]  ot;
        exp_t        sq[$];

        dl_shift_pipe #(.NUM_BITS(32), .NUM_STAGES(S), .TAG_BITS(5)) u_dut (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (sw_valid),
            .in_ready  (rdy),
            .in_a      (sw_a),
            .in_shift  (sw_shift),
            .in_op     (sw_op),
            .in_tag    (sw_tag),
            .out_valid (ov),
            .out_ready (sw_ready),
            .out_data  (od),
            .out_tag   (ot)
        );

        always @(negedge clk) begin
            exp_t e;
            if (!rst) begin
                if (ov && sw_ready) begin
                    if (sq.size() == 0) begin
                        checks++;
                        $display("FAIL sweep%0d_unexpected: got data %h, required no output", S, od);
                    end else begin
                        e = sq.pop_front();
                        check($sformatf("sweep%0d_data", S), 64'(od), 64'(e.data));
                        check($sformatf("sweep%0d_tag", S), 64'(ot), 64'(e.tag));
                        if (e.chk_lat) check($sformatf("sweep%0d_latency", S), 64'(cyc - e.cyc), 64'(S));
                    end
                end
                if (sw_valid && rdy) begin
                    e.data = model(sw_a, sw_shift, sw_op);
                    e.tag = sw_tag; e.cyc = cyc; e.chk_lat = sw_lat; e.b2b = 0;
                    sq.push_back(e);
                end
            end
        end

        initial begin
            @(posedge sw_done);
            check($sformatf("sweep%0d_drain", S), 64'(sq.size()), 64'(0));
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running, required finish");
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_out_data", 64'(out_data), 64'(0));
        check("rst_out_tag", 64'(out_tag), 64'(0));
        check("rst_in_ready", 64'(in_ready), 64'(1));
        @(posedge clk); #1;

        // basic ops, latency checked
        send(32'h8000_00F0, 5'd4, 2'b00, 5'd1, 32'h0000_0F00, 1, 1, 0);
        send(32'h8000_00F0, 5'd4, 2'b01, 5'd2, 32'h0800_000F, 1, 1, 0);
        send(32'h8000_00F0, 5'd4, 2'b10, 5'd3, 32'hF800_000F, 1, 1, 0);
        send(32'h8000_00F0, 5'd4, 2'b11, 5'd4, 32'h0800_000F, 1, 1, 0);
        // edge amounts
        send(32'h8000_0000, 5'd31, 2'b10, 5'd5, 32'hFFFF_FFFF, 1, 1, 0);
        send(32'h0000_0001, 5'd31, 2'b00, 5'd6, 32'h8000_0000, 1, 1, 0);
        send(32'h8000_00F0, 5'd0, 2'b10, 5'd7, 32'h8000_00F0, 1, 1, 0);
        send(32'h8000_00F0, 5'd0, 2'b11, 5'd8, 32'h8000_00F0, 1, 1, 0);
        send(32'h8000_00F0, 5'd0, 2'b00, 5'd9, 32'h8000_00F0, 1, 1, 0);
        send(32'h0000_0001, 5'd1, 2'b11, 5'd10, ROR_1_BY_1, 1, 1, 0);
        repeat (5) @(posedge clk); #1;

        // backpressure: two ops fill the pipe, third must wait
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++)
            send(32'hA5A5_0000 + 32'(i), 5'd8, 2'b00, 5'(i), 32'hA500_0000 | (32'(i) << 8), 1, 0, 0);
        in_valid = 1'b1; in_a = 32'hA5A5_0002; in_shift = 5'd8; in_op = 2'b00; in_tag = 5'd2;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_in_ready", 64'(in_ready), 64'(0));
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        for (int i = 2; i < 6; i++)
            send(32'hA5A5_0000 + 32'(i), 5'd8, 2'b00, 5'(i), 32'hA500_0000 | (32'(i) << 8), 1, 0, 0);
        repeat (6) @(posedge clk); #1;
        check("bp_drain", 64'(q.size()), 64'(0));

        // bubble collapse: B fills the empty stage behind stalled A
        send(32'h0000_00FF, 5'd4, 2'b00, 5'd11, 32'h0000_0FF0, 1, 0, 0);
        @(posedge clk); #1;
        out_ready = 1'b0;
        send(32'hF000_0000, 5'd4, 2'b10, 5'd12, 32'hFF00_0000, 1, 0, 1);
        @(negedge clk);
        check("bubble_in_ready", 64'(in_ready), 64'(0));
        check("bubble_head_tag", 64'(out_tag), 64'(11));
        @(posedge clk); #1;
        out_ready = 1'b1;
        repeat (4) @(posedge clk); #1;
        check("bubble_drain", 64'(q.size()), 64'(0));

        // reset with two ops in flight: neither may ever appear
        out_ready = 1'b0;
        send(32'h1234_5678, 5'd3, 2'b01, 5'd20, 32'h0, 0, 0, 0);
        send(32'h1234_5678, 5'd5, 2'b00, 5'd21, 32'h0, 0, 0, 0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("flush_out_valid", 64'(out_valid), 64'(0));
        check("flush_out_data", 64'(out_data), 64'(0));
        check("flush_in_ready", 64'(in_ready), 64'(1));
        @(posedge clk); #1;
        out_ready = 1'b1;
        repeat (8) @(posedge clk); #1;

        // sweep: one latency probe into empty pipes, then random traffic
        sw_ready = 1'b1; sw_valid = 1'b1; sw_a = 32'h8000_00F0; sw_shift = 5'd4;
        sw_op = 2'b10; sw_tag = 5'd7; sw_lat = 1;
        @(posedge clk); #1;
        sw_valid = 1'b0; sw_lat = 0;
        repeat (8) @(posedge clk); #1;
        repeat (400) begin
            sw_valid = ($urandom_range(0, 3) != 0);
            sw_a     = $urandom;
            sw_shift = 5'($urandom_range(0, 31));
            sw_op    = 2'($urandom_range(0, 3));
            sw_tag   = 5'($urandom_range(0, 31));
            sw_ready = ($urandom_range(0, 2) != 0);
            @(posedge clk); #1;
        end
        sw_valid = 1'b0; sw_ready = 1'b1;
        repeat (20) @(posedge clk); #1;
        sw_done = 1'b1;
        #1;
        check("main_queue_empty", 64'(q.size()), 64'(0));
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
